// File: rtl/apb_slave_regfile.sv
// APB3 completer holding a word-addressed register file with programmable
// wait states and per-word write protection reported through PSLVERR.
module apb_slave_regfile #(
  parameter int                ADDR_WIDTH  = 32,
  parameter int                DATA_WIDTH  = 32,
  parameter int                DEPTH       = 16,
  parameter int                WAIT_STATES = 1,
  parameter logic [DEPTH-1:0]  RO_MASK     = '0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [IDX_W-1:0]      w_idx;
  logic                  w_setup;
  logic                  w_unused_addr;

  assign w_idx         = PADDR[IDX_W-1:0];
  assign w_setup       = PSEL && !PENABLE;
  assign w_unused_addr = ^PADDR[ADDR_WIDTH-1:IDX_W];

  assign PRDATA  = r_prdata;
  assign PREADY  = (r_state == S_DONE);
  assign PSLVERR = (r_state == S_DONE) && r_write && RO_MASK[r_idx];

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_prdata <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_idx   <= w_idx;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            // Zero-wait reads must fetch from the live address: r_idx is not yet loaded.
            if (WAIT_STATES == 0) begin
              r_state <= S_DONE;
              if (!PWRITE) r_prdata <= r_mem[w_idx];
            end else begin
              r_cnt   <= 4'(WAIT_STATES);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!PSEL) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= S_DONE;
              if (!r_write) r_prdata <= r_mem[r_idx];
            end
          end
        end
        S_DONE: begin
          if (r_write && !RO_MASK[r_idx]) r_mem[r_idx] <= r_wdata;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed and randomized APB transfers against three completer configurations,
// checked against a per-instance word array model.
module tb_apb_slave_regfile;

  logic        PCLK;
  logic        PRESET;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  int          total;
  int          bad;

  int          ws_tab [3] = '{1, 0, 3};
  logic [15:0] ro_tab [3] = '{16'h0008, 16'h0000, 16'h8001};
  logic [31:0] model  [3][16];
  logic [31:0] last_rd [3];

  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16),
                      .WAIT_STATES(1), .RO_MASK(16'h0008)) u0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16),
                      .WAIT_STATES(0), .RO_MASK(16'h0000)) u1 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16),
                      .WAIT_STATES(3), .RO_MASK(16'h8001)) u2 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkint(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      last_rd[k] = '0;
      for (int i = 0; i < 16; i++) model[k][i] = '0;
    end
  endtask

  // One complete transfer on instance k; results compared against the model.
  task automatic xfer(input int k, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input string tag);
    int   idx;
    int   n;
    logic exp_err;
    idx = int'(addr[3:0]);
    @(negedge PCLK);
    psel    = 3'b000;
    psel[k] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(negedge PCLK);
    penable = 1'b1;
    n = 1;
    while (!pready[k] && n < 40) begin
      @(negedge PCLK);
      n++;
    end
    check1({tag, " ready"}, pready[k], 1'b1);
    checkint({tag, " latency"}, n, ws_tab[k] + 1);
    if (wr) begin
      exp_err = ro_tab[k][idx];
      check1({tag, " slverr"}, pslverr[k], exp_err);
      check32({tag, " prdata-hold"}, prdata[k], last_rd[k]);
      if (!exp_err) model[k][idx] = wdata;
    end else begin
      check1({tag, " slverr"}, pslverr[k], 1'b0);
      check32({tag, " rdata"}, prdata[k], model[k][idx]);
      last_rd[k] = model[k][idx];
    end
  endtask

  task automatic idle_check(input int k, input string tag);
    @(negedge PCLK);
    psel    = 3'b000;
    penable = 1'b0;
    @(negedge PCLK);
    check1({tag, " idle-ready"}, pready[k], 1'b0);
    check1({tag, " idle-slverr"}, pslverr[k], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    psel    = 3'b000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    clear_model();

    // Reset held for three cycles
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    for (int k = 0; k < 3; k++) begin
      check1("rst ready", pready[k], 1'b0);
      check1("rst slverr", pslverr[k], 1'b0);
      check32("rst prdata", prdata[k], 32'h0);
    end
    PRESET = 1'b0;

    for (int i = 0; i < 16; i++) xfer(0, 1'b0, 32'(i), 32'h0, "rst-read");
    idle_check(0, "rst");

    // Single-wait write then read through a wrapped address
    xfer(0, 1'b1, 32'h1211_1111, 32'h0000_0005, "t2-wr");
    xfer(0, 1'b0, 32'h1211_1111, 32'h0, "t2-rd");
    check32("t2 value", prdata[0], 32'h0000_0005);
    idle_check(0, "t2");

    // Operand fetch and product write-back as the requester would do it
    xfer(0, 1'b1, 32'h1211_1111, 32'd3, "t3-op1");
    xfer(0, 1'b1, 32'h1312_2222, 32'd7, "t3-op2");
    xfer(0, 1'b0, 32'h1211_1111, 32'h0, "t3-rd1");
    xfer(0, 1'b0, 32'h1312_2222, 32'h0, "t3-rd2");
    xfer(0, 1'b1, 32'h1111_0000, 32'(model[0][1][15:0] * model[0][2][15:0]), "t3-prod");
    xfer(0, 1'b0, 32'h1111_0000, 32'h0, "t3-rdprod");
    check32("t3 idx0", prdata[0], 32'h0000_0015);

    // Write to a protected word
    xfer(0, 1'b1, 32'h0000_0003, 32'h0000_DEAD, "t4-wr");
    xfer(0, 1'b0, 32'h0000_0003, 32'h0, "t4-rd");
    check32("t4 idx3", prdata[0], 32'h0);
    idle_check(0, "t4");

    // Zero and three wait states, back-to-back alternating reads
    for (int k = 1; k < 3; k++) begin
      xfer(k, 1'b1, 32'hA000_0001, 32'h1111_AAAA + 32'(k), "t5-wr1");
      xfer(k, 1'b1, 32'hB000_0002, 32'h2222_5555 + 32'(k), "t5-wr2");
      for (int j = 0; j < 6; j++)
        xfer(k, 1'b0, (j % 2 == 0) ? 32'h0000_0001 : 32'h0000_0002, 32'h0, "t5-b2b");
      idle_check(k, "t5");
    end

    // Abort by PSEL drop while waiting: no write may land
    @(negedge PCLK);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h5; pwdata = 32'h1234;
    @(negedge PCLK);
    penable = 1'b1;
    check1("abort wait", pready[2], 1'b0);
    psel = 3'b000;
    @(negedge PCLK);
    check1("abort ready", pready[2], 1'b0);
    xfer(2, 1'b0, 32'h5, 32'h0, "abort-rd");

    // Reset in the middle of a waited write
    xfer(0, 1'b1, 32'h4, 32'h5555, "t6-pre");
    @(negedge PCLK);
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hAAAA;
    @(negedge PCLK);
    penable = 1'b1;
    check1("t6 waiting", pready[0], 1'b0);
    PRESET = 1'b1;
    @(negedge PCLK);
    check1("t6 ready", pready[0], 1'b0);
    check1("t6 slverr", pslverr[0], 1'b0);
    check32("t6 prdata", prdata[0], 32'h0);
    PRESET = 1'b0;
    psel = 3'b000;
    penable = 1'b0;
    clear_model();
    @(negedge PCLK);
    check1("t6 idle", pready[0], 1'b0);
    xfer(0, 1'b0, 32'h4, 32'h0, "t6-rd");
    check32("t6 idx4", prdata[0], 32'h0);

    // Randomized traffic
    for (int r = 0; r < 80; r++) begin
      int k;
      k = int'($urandom_range(0, 2));
      xfer(k, 1'($urandom_range(0, 1)), $urandom, $urandom, "rand");
      if ($urandom_range(0, 3) == 0) idle_check(k, "rand");
    end
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 16; i++) xfer(k, 1'b0, 32'(i), 32'h0, "final-rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
